// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// Grants one byte at a time, waits for completion or timeout, then idles one GAP cycle.
module uart_tx_arbiter #(
  parameter int width      = 8,
  parameter int TX_TIMEOUT = 60000
) (
  input  logic               sys_clk,
  input  logic               sys_reset,
  input  logic [3:0]         req_valid,
  input  logic [4*width-1:0] req_data,
  output logic [3:0]         req_ack,
  output logic [3:0]         req_done,
  output logic               uart_tx_en,
  output logic [width-1:0]   uart_tx_data,
  input  logic               uart_tx_done,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic               timeout_err,
  output logic [1:0]         state_dbg
);

  // Handshake: a requester holds req_valid/req_data stable until its req_ack
  // pulse; dropping req_valid earlier withdraws the request. The transmitter
  // sees a one-cycle uart_tx_en and answers with a one-cycle uart_tx_done.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } state_t;

  localparam int CW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      last_grant;
  logic [1:0]      winner;
  logic            any_req;

  // Scan from lowest to highest priority so the nearest requester after
  // last_grant overwrites the rest.
  always_comb begin
    logic [1:0] idx;
    winner  = 2'd0;
    any_req = 1'b0;
    idx     = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (req_valid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= 2'd3;
      req_ack      <= '0;
      req_done     <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      grant_id     <= 2'd0;
      timeout_err  <= 1'b0;
    end else begin
      req_ack    <= '0;
      req_done   <= '0;
      uart_tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= WAIT_DONE;
            cnt          <= '0;
            grant_id     <= winner;
            uart_tx_data <= req_data[winner*width +: width];
            req_ack      <= 4'b0001 << winner;
            uart_tx_en   <= 1'b1;
          end
        end
        WAIT_DONE: begin
          // Completion takes precedence over a timeout in the same cycle.
          if (uart_tx_done) begin
            req_done   <= 4'b0001 << grant_id;
            last_grant <= grant_id;
            state      <= GAP;
          end else if (cnt == CW'(TX_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single transfer, stray done, timeout,
// done/timeout collision, async reset, round-robin fairness and rotation.
module tb_uart_tx_arbiter;

  localparam int W = 8;

  logic           sys_clk;
  logic           sys_reset;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_ack;
  logic [3:0]     req_done;
  logic           uart_tx_en;
  logic [W-1:0]   uart_tx_data;
  logic           uart_tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;
  logic [1:0]     state_dbg;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  uart_tx_arbiter #(.width(W), .TX_TIMEOUT(16)) dut (
    .sys_clk(sys_clk),
    .sys_reset(sys_reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ack(req_ack),
    .req_done(req_done),
    .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_done(uart_tx_done),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: waits for a grant and compares against the expected queue.
  task automatic wait_grant(input string tag, input logic [3:0] exp_ack,
                            input logic [1:0] exp_id, output int n);
    logic [W-1:0] exp_byte;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (uart_tx_en === 1'b1) break;
    end
    chk({tag, "_tx_en"}, uart_tx_en, 1);
    exp_byte = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_tx_data"}, uart_tx_data, exp_byte);
    chk({tag, "_ack"}, req_ack, exp_ack);
    chk({tag, "_grant_id"}, grant_id, exp_id);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic pulse_done(input string tag, input logic [3:0] exp_done);
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    chk({tag, "_req_done"}, req_done, exp_done);
    chk({tag, "_gap_busy"}, busy, 1);
  endtask

  initial begin
    int n;
    logic saw_done;

    sys_reset    = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    uart_tx_done = 1'b0;
    #1;
    chk("rst_ack", req_ack, 0);
    chk("rst_tx_en", uart_tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state_dbg, 0);
    tick();
    tick();
    sys_reset = 1'b0;

    // Single request from requester 1
    req_valid       = 4'b0010;
    req_data[15:8]  = 8'h55;
    exp_q.push_back(8'h55);
    wait_grant("single", 4'b0010, 2'd1, n);
    chk("single_state", state_dbg, 1);
    req_valid = 4'b0000;
    req_data[15:8] = 8'hFF;
    tick();
    chk("single_en_pulse", uart_tx_en, 0);
    chk("single_ack_pulse", req_ack, 0);
    chk("single_data_hold", uart_tx_data, 8'h55);
    pulse_done("single", 4'b0010);
    tick();
    chk("single_done_pulse", req_done, 0);
    chk("single_idle_busy", busy, 0);

    // Stray done in IDLE
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    chk("stray_done", req_done, 0);
    chk("stray_busy", busy, 0);
    tick();
    chk("stray_done2", req_done, 0);

    // Done arriving on the same edge the timeout would fire
    req_valid       = 4'b1000;
    req_data[31:24] = 8'h9E;
    exp_q.push_back(8'h9E);
    wait_grant("collide", 4'b1000, 2'd3, n);
    req_valid = 4'b0000;
    repeat (15) tick();
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    chk("collide_req_done", req_done, 4'b1000);
    chk("collide_no_err", timeout_err, 0);
    chk("collide_state", state_dbg, 2);
    tick();

    // Timeout: requester 2, no done
    req_valid       = 4'b0100;
    req_data[23:16] = 8'h77;
    exp_q.push_back(8'h77);
    wait_grant("tmo", 4'b0100, 2'd2, n);
    req_valid = 4'b0000;
    saw_done = 1'b0;
    n = 0;
    while (n < 20 && timeout_err !== 1'b1) begin
      tick();
      n++;
      if (req_done !== 4'b0000) saw_done = 1'b1;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_no_done", saw_done, 0);
    chk("tmo_gap_state", state_dbg, 2);
    tick();
    chk("tmo_idle_busy", busy, 0);

    // Following request is served normally; error stays sticky
    req_valid     = 4'b0001;
    req_data[7:0] = 8'h3C;
    exp_q.push_back(8'h3C);
    wait_grant("after_tmo", 4'b0001, 2'd0, n);
    chk("after_tmo_err", timeout_err, 1);
    req_valid = 4'b0000;
    pulse_done("after_tmo", 4'b0001);
    tick();

    // Asynchronous reset during WAIT_DONE
    req_valid      = 4'b0010;
    req_data[15:8] = 8'h12;
    exp_q.push_back(8'h12);
    wait_grant("rstmid", 4'b0010, 2'd1, n);
    req_valid = 4'b0000;
    tick();
    tick();
    #2;
    sys_reset = 1'b1;
    #1;
    chk("rstmid_data", uart_tx_data, 0);
    chk("rstmid_grant", grant_id, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_err", timeout_err, 0);
    chk("rstmid_ack_done", {req_ack, req_done, uart_tx_en}, 0);
    req_valid = 4'b1111;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick();
    #2;
    sys_reset = 1'b0;

    // Fairness with all four requesters valid
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'hA0 + 8'(i % 4));
      wait_grant($sformatf("fair%0d", i), 4'b0001 << (i % 4), 2'(i % 4), n);
      if (i > 0) chk($sformatf("fair%0d_spacing", i), n, 2);
      pulse_done($sformatf("fair%0d", i), 4'b0001 << (i % 4));
    end
    req_valid = 4'b0000;
    tick();

    // Rotation: requester 2 held, requester 0 joins mid-transfer
    req_valid = 4'b0100;
    req_data  = {8'h00, 8'h52, 8'h00, 8'h50};
    exp_q.push_back(8'h52);
    wait_grant("rot_a", 4'b0100, 2'd2, n);
    tick();
    req_valid = 4'b0101;
    pulse_done("rot_a", 4'b0100);
    exp_q.push_back(8'h50);
    wait_grant("rot_b", 4'b0001, 2'd0, n);
    req_valid = 4'b0100;
    pulse_done("rot_b", 4'b0001);
    exp_q.push_back(8'h52);
    wait_grant("rot_c", 4'b0100, 2'd2, n);
    req_valid = 4'b0000;
    pulse_done("rot_c", 4'b0100);
    tick();
    chk("final_busy", busy, 0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: width, 8, byte width of each request and of the transmitter data bus.
REQ-002 Parameter: TX_TIMEOUT, 60000, sys_clk cycles allowed between uart_tx_en and uart_tx_done before abort.
REQ-003 sys_clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 sys_reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  4  requester i holds a byte for transmission.
REQ-006 req_data  input  4*width  packed request bytes; requester i at [i*width +: width].
REQ-007 req_ack  output  4  one-hot, one-cycle pulse; byte of requester i captured.
REQ-008 req_done  output  4  one-hot, one-cycle pulse; byte of requester i fully transmitted.
REQ-009 uart_tx_en  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-010 uart_tx_data  output  width  byte presented to the transmitter; held until the next grant.
REQ-011 uart_tx_done  input  1  completion pulse from the transmitter.
REQ-012 grant_id  output  2  index of the most recently granted requester.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 timeout_err  output  1  sticky flag; set on timeout, cleared only by reset.

Function
REQ-015 The block SHALL use a three-state FSM: IDLE, WAIT_DONE, GAP.
REQ-016 In IDLE, with any req_valid bit high at a clock edge, the block SHALL select a winner, capture its req_data into uart_tx_data, set grant_id, and enter WAIT_DONE.
REQ-017 req_ack[winner] and uart_tx_en SHALL both be high for exactly the one cycle following that edge.
REQ-018 Arbitration SHALL be round-robin: priority order last_grant+1, +2, +3, +0, modulo 4.
REQ-019 last_grant SHALL update only on a successful completion or a timeout.
REQ-020 Requesters SHALL hold req_valid and req_data stable until req_ack; dropping req_valid before ack withdraws the request without error.
REQ-021 Changes on req_data after ack SHALL NOT affect uart_tx_data.
REQ-022 In WAIT_DONE a cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-023 uart_tx_done high in WAIT_DONE SHALL pulse req_done[grant_id] in the next cycle and move to GAP.
REQ-024 If the counter reaches TX_TIMEOUT-1 without uart_tx_done, the block SHALL set timeout_err, SHALL NOT pulse req_done, and SHALL move to GAP.
REQ-025 If uart_tx_done and the timeout occur in the same cycle, completion SHALL win: req_done pulses and timeout_err is unchanged.
REQ-026 GAP SHALL last exactly one cycle, then return to IDLE; no grant is made in GAP.
REQ-027 uart_tx_done in IDLE or GAP SHALL be ignored.
REQ-028 Minimum spacing: consecutive uart_tx_en pulses SHALL be separated by at least the done cycle + GAP + the IDLE grant edge.
REQ-029 At most one req_ack bit and at most one req_done bit SHALL be high in any cycle.
REQ-030 busy SHALL be high in WAIT_DONE and GAP, and low in IDLE.

Reset
REQ-031 While sys_reset is high, all outputs SHALL be 0 immediately (asynchronous), the FSM SHALL be in IDLE, the counter SHALL be 0, and last_grant SHALL be 3, so requester 0 has first priority.
REQ-032 Reset mid-WAIT_DONE SHALL abandon the transfer without req_done. The transmitter's in-flight frame is not this block's concern.
REQ-033 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with req_valid nonzero.

Verification
REQ-034 Single request: req_valid=4'b0010, req_data[15:8]=8'h55 -> req_ack=4'b0010 and uart_tx_en for one cycle, uart_tx_data=8'h55, grant_id=1, busy=1; uart_tx_done -> req_done=4'b0010 next cycle, busy=0 two cycles after done.
REQ-035 Fairness: all four valid continuously with bytes 8'hA0..8'hA3 -> uart_tx_data sequence A0, A1, A2, A3, A0; exactly one req_ack per transfer.
REQ-036 Rotation: requester 2 held valid; requester 0 asserts during requester 2's WAIT_DONE -> next grant is 0, then 2.
REQ-037 Timeout: TX_TIMEOUT=16, uart_tx_done never asserted -> timeout_err=1 within 16 cycles after uart_tx_en, no req_done, IDLE after GAP; a following request is granted normally with timeout_err still 1.
REQ-038 Reset mid-transfer: sys_reset pulsed during WAIT_DONE -> all outputs 0 asynchronously, timeout_err cleared; with 4'b1111 pending afterward, the first grant is requester 0.
REQ-039 Stray done: uart_tx_done pulsed in IDLE with no requests -> no req_done, busy stays 0.
